// File: rtl/tweakey_stream_hash.sv
// tweakey_stream_hash
//   Multi-cycle Toeplitz hash that derives the 128-bit Blink-64 tweakey from a
//   128-bit tweak and two 191-bit hash keys. It absorbs CHUNK tweak bits per
//   cycle, so a job takes 128/CHUNK RUN cycles. Its result is bit-identical to
//   the combinational tweakey generator:
//     H(t, K)[k] = XOR_{j=0..127} (t[j] & K[j+63-k]),  k = 0..63
//
// Ports
//   clk        in    1  rising-edge clock
//   rst        in    1  asynchronous active-high reset
//   in_valid   in    1  tweak/key presented
//   in_ready   out   1  engine idle and able to accept
//   tweak      in  128  tweak, sampled on accept
//   key        in  382  key[190:0] = K0, key[381:191] = K1, sampled on accept
//   out_valid  out   1  result available (held until consumed)
//   out_ready  in    1  consumer takes the result
//   tweakey    out 128  {H(tweak,K1), H(tweak,K0)}, registered
//
// Build option
//   TWEAKEY_CLEAR_EN : when defined, tweak/key/accumulators and tweakey are
//                      zeroed as the result is consumed, so key material does
//                      not linger. When undefined, they keep their values
//                      until the next job.

module tweakey_stream_hash #(
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] tweak,
  input  logic [381:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] tweakey
);

  localparam int N  = 128 / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [127:0]  tw_q,    tw_d;
  logic [190:0]  k0_q,    k0_d;
  logic [190:0]  k1_q,    k1_d;
  logic [63:0]   acc0_q,  acc0_d;
  logic [63:0]   acc1_q,  acc1_d;
  logic [127:0]  tk_q,    tk_d;

  // Contribution of one chunk. The tweak and key registers are shifted right
  // every cycle, so bit i of the chunk always sees its window at kk[i+63:i],
  // applied bit-reversed: W_i[k] = kk[i+63-k].
  function automatic logic [63:0] absorb(input logic [CHUNK-1:0]  tw,
                                         input logic [CHUNK+62:0] kk);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (tw[i]) begin
        for (int k = 0; k < 64; k++) begin
          r[k] = r[k] ^ kk[i + 63 - k];
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tw_d    = tw_q;
    k0_d    = k0_q;
    k1_d    = k1_q;
    acc0_d  = acc0_q;
    acc1_d  = acc1_q;
    tk_d    = tk_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          tw_d    = tweak;
          k0_d    = key[190:0];
          k1_d    = key[381:191];
          acc0_d  = '0;
          acc1_d  = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc0_d = acc0_q ^ absorb(tw_q[CHUNK-1:0], k0_q[CHUNK+62:0]);
        acc1_d = acc1_q ^ absorb(tw_q[CHUNK-1:0], k1_q[CHUNK+62:0]);
        tw_d   = tw_q >> CHUNK;
        k0_d   = k0_q >> CHUNK;
        k1_d   = k1_q >> CHUNK;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Output register loads only here, on entry into DONE.
          tk_d    = {acc1_d, acc0_d};
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
`ifdef TWEAKEY_CLEAR_EN
          tw_d   = '0;
          k0_d   = '0;
          k1_d   = '0;
          acc0_d = '0;
          acc1_d = '0;
          tk_d   = '0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tw_q    <= '0;
      k0_q    <= '0;
      k1_q    <= '0;
      acc0_q  <= '0;
      acc1_q  <= '0;
      tk_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tw_q    <= tw_d;
      k0_q    <= k0_d;
      k1_q    <= k1_d;
      acc0_q  <= acc0_d;
      acc1_q  <= acc1_d;
      tk_q    <= tk_d;
    end
  end

  // Handshake outputs decode the state register only.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign tweakey   = tk_q;

endmodule

// File: doc/tweakey_stream_hash.md
# tweakey_stream_hash

Multi-cycle Toeplitz-hash engine that computes the 128-bit Blink-64 tweakey from a 128-bit tweak and a 382-bit hash key. It processes CHUNK tweak bits per cycle instead of the full 128×64 AND-XOR array at once. It sits between the tweak/key source and the cipher core. It is the area-reduced, flow-controlled counterpart of the combinational tweakey generator, and its result must be bit-identical to that generator.

## Interface
- CHUNK, 8, tweak bits absorbed per RUN cycle; legal values 1, 2, 4, 8, 16, 32, 64, 128.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  tweak/key presented.
- in_ready  out  1  engine can accept; high only in IDLE.
- tweak  in  128  tweak value, sampled on accept.
- key  in  382  hash keys: key[190:0] is K0 and key[381:191] is K1; sampled on accept.
- out_valid  out  1  tweakey result available.
- out_ready  in  1  consumer accepts result.
- tweakey  out  128  [63:0] = H(tweak, K0); [127:64] = H(tweak, K1).

## Operation
- Hash definition, for k in 0..63: H(t, K)[k] = XOR over j=0..127 of (t[j] & K[j+63-k]).
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - On in_valid & in_ready: latch tweak into a tweak register, latch both keys into key registers, clear both 64-bit accumulators, clear the chunk counter, and go to RUN.
- RUN: each cycle absorbs tweak bits j = c·CHUNK .. c·CHUNK+CHUNK-1, where c is the chunk counter.
  - For each such bit j with tweak[j]=1, XOR window W_j into the accumulator. W_j[k] = K[j+63-k], i.e. K[j+63:j] bit-reversed.
  - Both halves are computed in parallel.
  - Implementation: shift the tweak and key registers right by CHUNK per cycle, so the window always starts at bit 0.
- Chunk counter: width log2(128/CHUNK), minimum 1 bit.
  - After the last chunk (c = 128/CHUNK-1), go to DONE.
  - The counter wraps to 0; it has no other use.
- DONE: out_valid=1 and tweakey = accumulators.
  - tweakey holds stable until out_valid & out_ready, then the FSM returns to IDLE.
- in_valid is ignored outside IDLE.
- No result is dropped and none is duplicated.
- Single job in flight; no pipelining between jobs.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, tweakey=0, accumulators/counter/tweak/key registers = 0.
- Reset asserted mid-RUN or mid-DONE aborts the job immediately; nothing is output.
- Accept at edge e → RUN for N=128/CHUNK cycles → out_valid rises at edge e+N.
  - Example: CHUNK=8 gives N=16, latency 16.
- Handshake on the output side: out_ready held high in DONE → return to IDLE at the next edge, with in_ready=1 one cycle after the result is consumed.
- Throughput: one job per N+2 cycles.
- No combinational path from in_valid to in_ready or from out_ready to out_valid.
- tweakey is a registered output; it changes only on the entry edge into DONE.
  - It holds its value in IDLE and RUN (no glitch to 0) unless TWEAKEY_CLEAR_EN applies.

## Configuration
- TWEAKEY_CLEAR_EN defined:
  - On leaving DONE (output handshake), the tweak, key, accumulator registers and tweakey are zeroed. This limits key-material residency.
  - Output reads 0 while in IDLE/RUN.
- TWEAKEY_CLEAR_EN undefined:
  - Registers keep their last values until the next accept.
  - tweakey keeps the last result until the next DONE entry.

## Test plan
- Zero tweak: tweak=0, key=all ones, CHUNK=8 → out_valid at accept+16, tweakey=0.
- Unit tweak: tweak=1 (bit 0), key=all ones → tweakey=128'hFFFF…FFFF.
- Window endpoints:
  - tweak bit 0 only, K0=1<<63, K1=0 → tweakey=128'h1.
  - tweak bit 127 only, K0=0, K1=1<<190 → tweakey[127:64]=64'h1 and tweakey[63:0]=0.
- Diagonal key: tweak=all ones, K0=1<<100, K1=1<<100 → tweakey = all ones.
  - Then 1000 random vectors for each CHUNK in {1, 8, 128}, checked against the bit-level H definition.
- Backpressure: hold out_ready=0 for 20 cycles in DONE.
  - Required: tweakey stable, in_ready=0, and a second in_valid is ignored.
  - out_ready=1 → exactly one transfer, then in_ready=1 on the next cycle.
- Reset mid-RUN: assert rst at RUN cycle 5.
  - Required: out_valid=0, in_ready=1, tweakey=0 immediately.
  - A new job after reset returns the correct hash with the full N-cycle latency.
